// File: rtl/demux8_pkg.sv
// Shared types and constants for the 8-way 4-bit write demux and its read-side peers.
package demux8_pkg;
  localparam int DEMUX8_NREG = 8;
  localparam int DEMUX8_W    = 4;
  localparam int DEMUX8_SELW = 3;

  typedef logic [DEMUX8_SELW-1:0] sel_t;
  typedef logic [DEMUX8_W-1:0]    word_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_PEND  = 1'b1
  } pend_state_t;

  // Write counter stops at its ceiling instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction
endpackage

// File: rtl/demux8x1_wr_dec3to8.sv
// Enable-gated 3-to-8 one-hot decoder; produces register load enables and strobe next-state.
module dec3to8
  import demux8_pkg::*;
(
  input  logic                   en,
  input  sel_t                   sel,
  output logic [DEMUX8_NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/demux8x1_wr.sv
// Write-side 8-way demux: valid/ready intake, one-entry pending stage, eight 4-bit registers.
// Optional synchronous clear-all is built when DEMUX8_CLEAR_EN is defined.
module demux8x1_wr
  import demux8_pkg::*;
#(
  parameter int NREG = 8,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic [2:0]        in_sel,
  input  logic              hold,
`ifdef DEMUX8_CLEAR_EN
  input  logic              clr,
`endif
  output logic [NREG*W-1:0] q_flat,
  output logic [NREG-1:0]   wr_strobe,
  output logic              pending,
  output logic [7:0]        wr_count
);

  pend_state_t              state, state_n;
  logic                     accept, commit, flush;
  logic [W-1:0]             in_data_p;
  sel_t                     in_sel_p;
  logic [NREG-1:0]          load;
  logic [NREG-1:0][W-1:0]   regs;

`ifdef DEMUX8_CLEAR_EN
  assign flush = clr;
`else
  assign flush = 1'b0;
`endif

  assign pending = (state == ST_PEND);
  assign q_flat  = regs;

  always_comb begin
    in_ready = (!pending || !hold) && !flush;
    accept   = in_valid && in_ready;
    commit   = pending && !hold && !flush;
    state_n  = state;
    case (state)
      ST_EMPTY: if (accept) state_n = ST_PEND;
      ST_PEND:  if (commit && !accept) state_n = ST_EMPTY;
      default:  state_n = ST_EMPTY;
    endcase
    if (flush) state_n = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_n;
  end

  // Pending stage: payload only, qualified by state
  always_ff @(posedge clk) begin
    if (accept) begin
      in_data_p <= in_data;
      in_sel_p  <= in_sel;
    end
  end

  dec3to8 u_dec (
    .en     (commit),
    .sel    (in_sel_p),
    .onehot (load)
  );

  // Register bank commit stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs      <= '0;
      wr_strobe <= '0;
      wr_count  <= '0;
    end else if (flush) begin
      regs      <= '0;
      wr_strobe <= '0;
      wr_count  <= '0;
    end else begin
      wr_strobe <= load;
      for (int k = 0; k < NREG; k++) begin
        if (load[k]) regs[k] <= in_data_p;
      end
      if (commit) wr_count <= sat_inc(wr_count);
    end
  end

endmodule

// File: tb/tb_demux8x1_wr.sv
// Bench for demux8x1_wr: directed vector table, randomized run against a queue model, reset/clear corners.
module tb_demux8x1_wr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = '0;
  logic [2:0]  in_sel = '0;
  logic        hold = 1'b0;
`ifdef DEMUX8_CLEAR_EN
  logic        clr = 1'b0;
`endif
  logic [31:0] q_flat;
  logic [7:0]  wr_strobe;
  logic        pending;
  logic [7:0]  wr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux8x1_wr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .hold      (hold),
`ifdef DEMUX8_CLEAR_EN
    .clr       (clr),
`endif
    .q_flat    (q_flat),
    .wr_strobe (wr_strobe),
    .pending   (pending),
    .wr_count  (wr_count)
  );

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic [3:0]  data;
    logic        h;
    logic        rdy;
    logic [31:0] q;
    logic [7:0]  stb;
    logic        pend;
    logic [7:0]  cnt;
  } vec_t;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] data;
  } ent_t;

  vec_t       tbl[$];
  ent_t       mq[$];
  logic [3:0] mreg[8];
  int         mcnt;
  logic [7:0] mstb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [2:0] s, input logic [3:0] d, input logic h,
                     input logic rdy, input logic [31:0] q, input logic [7:0] stb,
                     input logic p, input logic [7:0] c);
    vec_t r;
    r.v = v; r.sel = s; r.data = d; r.h = h; r.rdy = rdy;
    r.q = q; r.stb = stb; r.pend = p; r.cnt = c;
    tbl.push_back(r);
  endtask

  task automatic model_clear();
    mq.delete();
    for (int k = 0; k < 8; k++) mreg[k] = '0;
    mcnt = 0;
    mstb = '0;
  endtask

  function automatic logic [31:0] model_q();
    logic [31:0] r;
    for (int k = 0; k < 8; k++) r[4*k +: 4] = mreg[k];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock of stimulus, with the model advanced at the edge and outputs compared after it.
  task automatic model_cycle(input logic v, input logic [3:0] d, input logic [2:0] s, input logic h,
                             input string tag);
    logic exp_rdy;
    ent_t e;
    @(negedge clk);
    in_valid = v; in_data = d; in_sel = s; hold = h;
    exp_rdy = (mq.size() == 0) || !h;
    #1 chk({tag, " ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    mstb = '0;
    if (mq.size() != 0 && !h) begin
      e = mq.pop_front();
      mreg[e.sel] = e.data;
      mstb[e.sel] = 1'b1;
      if (mcnt < 255) mcnt++;
    end
    if (v && exp_rdy) begin
      e.sel = s; e.data = d;
      mq.push_back(e);
    end
    #1;
    chk({tag, " q_flat"}, q_flat, model_q());
    chk({tag, " strobe"}, 32'(wr_strobe), 32'(mstb));
    chk({tag, " pending"}, 32'(pending), 32'(mq.size() != 0));
    chk({tag, " count"}, 32'(wr_count), 32'(mcnt));
  endtask

  initial begin
    logic       pv, ph;
    logic [3:0] pd;
    logic [2:0] ps;
    logic       stalled;

    // Reset state
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset q_flat", q_flat, 32'h0);
    chk("reset strobe", 32'(wr_strobe), 32'h0);
    chk("reset pending", 32'(pending), 32'h0);
    chk("reset count", 32'(wr_count), 32'h0);
    chk("reset ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    //   v  sel   data  h  rdy  q_flat         stb    p  cnt
    add(1, 3'd5, 4'hA, 0, 1, 32'h0000_0000, 8'h00, 1, 8'd0);
    add(0, 3'd0, 4'h0, 0, 1, 32'h00A0_0000, 8'h20, 0, 8'd1);
    add(0, 3'd0, 4'h0, 0, 1, 32'h00A0_0000, 8'h00, 0, 8'd1);
    add(1, 3'd0, 4'h1, 0, 1, 32'h00A0_0000, 8'h00, 1, 8'd1);
    add(1, 3'd1, 4'h2, 0, 1, 32'h00A0_0001, 8'h01, 1, 8'd2);
    add(1, 3'd2, 4'h3, 0, 1, 32'h00A0_0021, 8'h02, 1, 8'd3);
    add(1, 3'd3, 4'h4, 0, 1, 32'h00A0_0321, 8'h04, 1, 8'd4);
    add(1, 3'd4, 4'h5, 0, 1, 32'h00A0_4321, 8'h08, 1, 8'd5);
    add(1, 3'd5, 4'h6, 0, 1, 32'h00A5_4321, 8'h10, 1, 8'd6);
    add(1, 3'd6, 4'h7, 0, 1, 32'h0065_4321, 8'h20, 1, 8'd7);
    add(1, 3'd7, 4'h8, 0, 1, 32'h0765_4321, 8'h40, 1, 8'd8);
    add(0, 3'd0, 4'h0, 0, 1, 32'h8765_4321, 8'h80, 0, 8'd9);
    add(0, 3'd0, 4'h0, 0, 1, 32'h8765_4321, 8'h00, 0, 8'd9);
    add(1, 3'd2, 4'hE, 0, 1, 32'h8765_4321, 8'h00, 1, 8'd9);
    add(0, 3'd0, 4'h0, 1, 0, 32'h8765_4321, 8'h00, 1, 8'd9);
    add(1, 3'd0, 4'hF, 1, 0, 32'h8765_4321, 8'h00, 1, 8'd9);
    add(0, 3'd0, 4'h0, 1, 0, 32'h8765_4321, 8'h00, 1, 8'd9);
    add(0, 3'd0, 4'h0, 0, 1, 32'h8765_4E21, 8'h04, 0, 8'd10);
    add(0, 3'd0, 4'h0, 0, 1, 32'h8765_4E21, 8'h00, 0, 8'd10);
    add(1, 3'd7, 4'h9, 0, 1, 32'h8765_4E21, 8'h00, 1, 8'd10);
    add(1, 3'd7, 4'h4, 0, 1, 32'h9765_4E21, 8'h80, 1, 8'd11);
    add(0, 3'd0, 4'h0, 0, 1, 32'h4765_4E21, 8'h80, 0, 8'd12);
    add(0, 3'd0, 4'h0, 0, 1, 32'h4765_4E21, 8'h00, 0, 8'd12);

    foreach (tbl[i]) begin
      @(negedge clk);
      in_valid = tbl[i].v; in_sel = tbl[i].sel; in_data = tbl[i].data; hold = tbl[i].h;
      #1 chk($sformatf("vec%0d ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d q_flat", i), q_flat, tbl[i].q);
      chk($sformatf("vec%0d strobe", i), 32'(wr_strobe), 32'(tbl[i].stb));
      chk($sformatf("vec%0d pending", i), 32'(pending), 32'(tbl[i].pend));
      chk($sformatf("vec%0d count", i), 32'(wr_count), 32'(tbl[i].cnt));
    end

    // Randomized traffic; long enough to drive wr_count into saturation
    do_reset();
    stalled = 1'b0;
    pv = 1'b0; pd = '0; ps = '0;
    for (int n = 0; n < 800; n++) begin
      ph = ($urandom_range(0, 3) == 0);
      if (!stalled) begin
        pv = ($urandom_range(0, 3) != 0);
        pd = 4'($urandom);
        ps = 3'($urandom);
      end
      stalled = pv && (mq.size() != 0) && ph;
      model_cycle(pv, pd, ps, ph, $sformatf("rnd%0d", n));
    end
    model_cycle(1'b0, 4'h0, 3'd0, 1'b0, "drain");
    chk("saturated count", 32'(wr_count), 32'd255);

    // Reset while a word is pending
    do_reset();
    model_cycle(1'b1, 4'hF, 3'd1, 1'b0, "prerst");
    @(negedge clk);
    in_valid = 1'b0; hold = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst q_flat", q_flat, 32'h0);
    chk("midrst strobe", 32'(wr_strobe), 32'h0);
    chk("midrst pending", 32'(pending), 32'h0);
    chk("midrst count", 32'(wr_count), 32'h0);
    chk("midrst ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1; hold = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("postrst q_flat", q_flat, 32'h0);
    chk("postrst count", 32'(wr_count), 32'h0);

`ifdef DEMUX8_CLEAR_EN
    // Clear-all colliding with a pending commit
    for (int k = 0; k < 8; k++) model_cycle(1'b1, 4'hF, 3'(k), 1'b0, $sformatf("fill%0d", k));
    model_cycle(1'b1, 4'h5, 3'd0, 1'b0, "preclr");
    chk("filled q_flat", q_flat, 32'hFFFF_FFFF);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_sel = 3'd3; in_data = 4'h7; hold = 1'b0;
    #1 chk("clr ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("clr q_flat", q_flat, 32'h0);
    chk("clr count", 32'(wr_count), 32'h0);
    chk("clr strobe", 32'(wr_strobe), 32'h0);
    chk("clr pending", 32'(pending), 32'h0);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("postclr strobe", 32'(wr_strobe), 32'h0);
    chk("postclr q_flat", q_flat, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
